// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;
  localparam int LINE_ADDR_W    = 58;
  localparam int WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    ST_BYTE   = 2'b00,
    ST_HALF   = 2'b01,
    ST_WORD   = 2'b10,
    ST_DOUBLE = 2'b11
  } store_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;
endpackage

// File: rtl/dcache_store_merge.sv
// Positions a right-justified store into big-endian byte lanes (offset 0 = MSB)
// and merges those lanes into an existing cached word.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  store_type_t store_type,
  input  logic [2:0]  byte_offset,
  input  logic [63:0] data,
  input  logic [63:0] old_word,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic [63:0] merged
);
  logic [2:0]  lane;
  logic [7:0]  size_strb;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;

  always_comb begin
    lane      = 3'd0;
    size_strb = 8'hFF;
    size_mask = '1;
    lane_mask = '0;
    // lane is the least-significant strobe bit covered by the access
    case (store_type)
      ST_BYTE: begin
        lane      = 3'd7 - byte_offset;
        size_strb = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      ST_HALF: begin
        lane      = 3'd6 - {byte_offset[2:1], 1'b0};
        size_strb = 8'h03;
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      ST_WORD: begin
        lane      = 3'd4 - {byte_offset[2], 2'b00};
        size_strb = 8'h0F;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: ;
    endcase
    wstrb = size_strb << lane;
    wdata = (data & size_mask) << {lane, 3'b000};
    for (int b = 0; b < 8; b++) lane_mask[8*b +: 8] = {8{wstrb[b]}};
    merged = (old_word & ~lane_mask) | (wdata & lane_mask);
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 64B lines.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dc_req,
  input  logic [LINE_ADDR_W-1:0] dc_line_addr,
  input  logic [2:0]             dc_word_select,
  input  logic [2:0]             dc_byte_offset,
  input  logic [63:0]            dc_data_to_cache,
  input  logic                   dc_read_write_n,
  input  logic [1:0]             store_type,
  output logic                   dc_ack,
  output logic [63:0]            dc_data_from_cache,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [2:0]             mem_beat,
  output logic [63:0]            mem_wdata,
  output logic [7:0]             mem_wstrb,
  input  logic                   mem_ack,
  input  logic [63:0]            mem_rdata,
  output state_t                 state_dbg
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = LINE_ADDR_W - INDEX_W;

  // Handshake: a request is taken in IDLE when dc_req=1 and dc_ack=0; its fields
  // must hold until dc_ack pulses for one cycle. mem_req stays high until the
  // beat(s) are acknowledged by mem_ack; mem_ack with mem_req low is ignored.
  state_t               state;
  logic [NUM_SETS-1:0]  valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [63:0]          data_q [NUM_SETS][WORDS_PER_LINE];
  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           req_word;

  logic [INDEX_W-1:0]   in_index;
  logic [TAG_W-1:0]     in_tag;
  logic                 lookup_hit;
  logic                 accept;
  logic                 fill_we;
  logic                 store_hit_we;
  logic [7:0]           st_wstrb;
  logic [63:0]          st_wdata;
  logic [63:0]          st_merged;

  assign in_index     = dc_line_addr[INDEX_W-1:0];
  assign in_tag       = dc_line_addr[LINE_ADDR_W-1:INDEX_W];
  assign lookup_hit   = valid_q[in_index] && (tag_q[in_index] == in_tag);
  assign accept       = (state == IDLE) && dc_req && !dc_ack;
  assign fill_we      = (state == FILL) && mem_req && mem_ack;
  assign store_hit_we = accept && !dc_read_write_n && lookup_hit;
  assign state_dbg    = state;

  dcache_store_merge u_merge (
    .store_type  (store_type_t'(store_type)),
    .byte_offset (dc_byte_offset),
    .data        (dc_data_to_cache),
    .old_word    (data_q[in_index][dc_word_select]),
    .wstrb       (st_wstrb),
    .wdata       (st_wdata),
    .merged      (st_merged)
  );

  // Tag and data storage carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (fill_we) data_q[req_index][mem_beat] <= mem_rdata;
    else if (store_hit_we) data_q[in_index][dc_word_select] <= st_merged;
    if (fill_we && (mem_beat == 3'd7)) tag_q[req_index] <= req_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      valid_q            <= '0;
      dc_ack             <= 1'b0;
      dc_data_from_cache <= '0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_beat           <= '0;
      mem_wdata          <= '0;
      mem_wstrb          <= '0;
      req_index          <= '0;
      req_tag            <= '0;
      req_word           <= '0;
`ifdef DCACHE_STATS_EN
      hit_count          <= '0;
      miss_count         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_index <= in_index;
          req_tag   <= in_tag;
          req_word  <= dc_word_select;
          mem_addr  <= dc_line_addr;
`ifdef DCACHE_STATS_EN
          if (lookup_hit) hit_count <= hit_count + 32'd1;
          else            miss_count <= miss_count + 32'd1;
`endif
          if (dc_read_write_n) begin
            if (lookup_hit) begin
              dc_data_from_cache <= data_q[in_index][dc_word_select];
              dc_ack             <= 1'b1;
              state              <= RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_beat <= 3'd0;
              state    <= FILL;
            end
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_beat  <= dc_word_select;
            mem_wdata <= st_wdata;
            mem_wstrb <= st_wstrb;
            state     <= WRITE;
          end
        end
        FILL: if (mem_ack) begin
          if (mem_beat == req_word) dc_data_from_cache <= mem_rdata;
          if (mem_beat == 3'd7) begin
            valid_q[req_index] <= 1'b1;
            mem_req            <= 1'b0;
            dc_ack             <= 1'b1;
            state              <= RESP;
          end else begin
            mem_beat <= mem_beat + 3'd1;
          end
        end
        WRITE: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          dc_ack  <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          dc_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, reset-abort sequence and random
// traffic checked against a line-level cache/memory model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int BW = 134;  // {we, beat, strb, addr, wdata} per memory beat

  logic        clk = 1'b0;
  logic        reset;
  logic        dc_req;
  logic [57:0] dc_line_addr;
  logic [2:0]  dc_word_select;
  logic [2:0]  dc_byte_offset;
  logic [63:0] dc_data_to_cache;
  logic        dc_read_write_n;
  logic [1:0]  store_type;
  logic        dc_ack;
  logic [63:0] dc_data_from_cache;
  logic        mem_req;
  logic        mem_we;
  logic [57:0] mem_addr;
  logic [2:0]  mem_beat;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  state_t      state_dbg;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .dc_req(dc_req), .dc_line_addr(dc_line_addr),
    .dc_word_select(dc_word_select), .dc_byte_offset(dc_byte_offset),
    .dc_data_to_cache(dc_data_to_cache), .dc_read_write_n(dc_read_write_n),
    .store_type(store_type), .dc_ack(dc_ack), .dc_data_from_cache(dc_data_from_cache),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_beat(mem_beat),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] act_q[$];
  logic [63:0]   bmem [logic [60:0]];
  bit            model_valid [int];
  logic [57:0]   model_line  [int];
  logic [63:0]   last_load = 64'h0;
  int            ack_mode = 0;

  typedef struct {
    logic [57:0] line;
    logic [2:0]  word;
    logic [2:0]  off;
    logic [63:0] data;
    logic        rw;
    logic [1:0]  st;
    int          exp_beats;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [57:0] line, input logic [2:0] beat);
    logic [60:0] key = {line, beat};
    if (bmem.exists(key)) return bmem[key];
    return {line[31:0], 16'hBEEF, 13'h0, beat};
  endfunction

  // Lanes covered by a store, derived byte by byte from the big-endian rules.
  function automatic void store_exp(input logic [2:0] off, input logic [1:0] st,
                                    input logic [63:0] data,
                                    output logic [7:0] strb, output logic [63:0] wd);
    int n = 1 << st;
    int start = (int'(off) / n) * n;
    strb = 8'h00;
    wd   = 64'h0;
    for (int o = start; o < start + n; o++) begin
      strb[7-o] = 1'b1;
      wd[8*(7-o) +: 8] = data[8*(n-1-(o-start)) +: 8];
    end
  endfunction

  // Backing-memory responder: random acceptance, spurious acks while idle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 64'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (ack_mode == 1 || $urandom_range(0, 3) != 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 64'hDEAD_DEAD_DEAD_DEAD : mem_rd(mem_addr, mem_beat);
          act_q.push_back({mem_we, mem_beat, mem_we ? mem_wstrb : 8'h00, mem_addr,
                           mem_we ? mem_wdata : 64'h0});
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic run_and_check(input string nm, input logic [57:0] line, input logic [2:0] word,
                               input logic [2:0] off, input logic [63:0] data, input logic rw,
                               input logic [1:0] st, input int exp_beats, input logic [7:0] exp_strb,
                               input logic [63:0] exp_wd, input logic [63:0] exp_rd, input int exp_lat);
    int lat;
    bit got;
    logic [63:0] rdata;
    exp_q.delete();
    if (exp_beats == 8)
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 3'(k), 8'h00, line, 64'h0});
    else if (exp_beats == 1)
      exp_q.push_back({1'b1, word, exp_strb, line, exp_wd});
    act_q.delete();
    @(negedge clk);
    dc_line_addr     = line;
    dc_word_select   = word;
    dc_byte_offset   = off;
    dc_data_to_cache = data;
    dc_read_write_n  = rw;
    store_type       = st;
    dc_req           = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      got = dc_ack;
    end
    chk({nm, " ack_seen"}, got, 1);
    rdata = dc_data_from_cache;
    chk({nm, " mem_req_low_at_ack"}, mem_req, 0);
    dc_req = 1'b0;
    chk({nm, " beat_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s beat%0d", nm, i), act_q[i], exp_q[i]);
    if (rw) chk({nm, " load_data"}, rdata, exp_rd);
    else    chk({nm, " store_data_held"}, rdata, last_load);
    if (exp_lat != 0) chk({nm, " hit_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({nm, " ack_single_cycle"}, dc_ack, 0);
  endtask

  task automatic model_update(input logic [57:0] line, input logic [2:0] word, input logic [2:0] off,
                              input logic [63:0] data, input logic rw, input logic [1:0] st);
    logic [7:0]  strb;
    logic [63:0] wd;
    logic [63:0] cur;
    if (rw) begin
      model_valid[int'(line % 64)] = 1'b1;
      model_line[int'(line % 64)]  = line;
      last_load = mem_rd(line, word);
    end else begin
      store_exp(off, st, data, strb, wd);
      cur = mem_rd(line, word);
      for (int b = 0; b < 8; b++) if (strb[b]) cur[8*b +: 8] = wd[8*b +: 8];
      bmem[{line, word}] = cur;
    end
  endtask

  task automatic model_op(input string nm, input logic [57:0] line, input logic [2:0] word,
                          input logic [2:0] off, input logic [63:0] data, input logic rw,
                          input logic [1:0] st);
    bit hit;
    logic [7:0]  strb;
    logic [63:0] wd;
    hit = model_valid.exists(int'(line % 64)) && model_line[int'(line % 64)] == line;
    store_exp(off, st, data, strb, wd);
    if (rw) run_and_check(nm, line, word, off, data, rw, st, hit ? 0 : 8, 8'h00, 64'h0,
                          mem_rd(line, word), hit ? 1 : 0);
    else    run_and_check(nm, line, word, off, data, rw, st, 1, strb, wd, 64'h0, 0);
    model_update(line, word, off, data, rw, st);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    dc_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_valid.delete();
    model_line.delete();
    last_load = 64'h0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [57:0] lines[6];
    int waited;
    lines = '{58'h40, 58'h80, 58'h99, 58'h1D9, 58'h3, 58'h12345};
    for (int k = 0; k < 8; k++) bmem[{58'h40, 3'(k)}] = 64'h1000 + 64'(k);

    reset = 1'b1; dc_req = 1'b0; dc_line_addr = '0; dc_word_select = '0;
    dc_byte_offset = '0; dc_data_to_cache = '0; dc_read_write_n = 1'b1; store_type = '0;
    repeat (2) @(negedge clk);
    chk("rst dc_ack", dc_ack, 0);
    chk("rst dc_data_from_cache", dc_data_from_cache, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_beat", mem_beat, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst state", state_dbg, IDLE);
    reset = 1'b0;

    tbl[0]  = '{58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 8, 8'h00, 64'h0, 64'h1003, 0};
    tbl[1]  = '{58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h1003, 1};
    tbl[2]  = '{58'h40, 3'd3, 3'd2, 64'h1234_56AB, 1'b0, 2'd0, 1, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 0};
    tbl[3]  = '{58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h0000_AB00_0000_1003, 1};
    tbl[4]  = '{58'h40, 3'd0, 3'd3, 64'hFFFF_CDEF, 1'b0, 2'd1, 1, 8'h30, 64'h0000_CDEF_0000_0000, 64'h0, 0};
    tbl[5]  = '{58'h40, 3'd0, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h0000_CDEF_0000_1000, 1};
    tbl[6]  = '{58'h40, 3'd7, 3'd5, 64'hAAAA_5555_89AB_CDEF, 1'b0, 2'd2, 1, 8'h0F, 64'h0000_0000_89AB_CDEF, 64'h0, 0};
    tbl[7]  = '{58'h40, 3'd7, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF, 1};
    tbl[8]  = '{58'h99, 3'd5, 3'd6, 64'h1122_3344_5566_7788, 1'b0, 2'd3, 1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0};
    tbl[9]  = '{58'h99, 3'd5, 3'd0, 64'h0, 1'b1, 2'd0, 8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 0};
    tbl[10] = '{58'h99, 3'd5, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1};
    tbl[11] = '{58'h80, 3'd3, 3'd7, 64'hFFFF_FF5A, 1'b0, 2'd0, 1, 8'h01, 64'h0000_0000_0000_005A, 64'h0, 0};
    tbl[12] = '{58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 0, 8'h00, 64'h0, 64'h0000_AB00_0000_1003, 1};
    tbl[13] = '{58'h80, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 8, 8'h00, 64'h0, 64'h0000_0080_BEEF_005A, 0};
    tbl[14] = '{58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0, 8, 8'h00, 64'h0, 64'h0000_AB00_0000_1003, 0};
    for (int i = 0; i < 15; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i].line, tbl[i].word, tbl[i].off, tbl[i].data,
                    tbl[i].rw, tbl[i].st, tbl[i].exp_beats, tbl[i].exp_strb, tbl[i].exp_wd,
                    tbl[i].exp_rd, tbl[i].exp_lat);
      model_update(tbl[i].line, tbl[i].word, tbl[i].off, tbl[i].data, tbl[i].rw, tbl[i].st);
    end

    // Reset arriving in the middle of a line fill.
    ack_mode = 1;
    @(negedge clk);
    dc_line_addr = 58'h2A0; dc_word_select = 3'd1; dc_read_write_n = 1'b1; dc_req = 1'b1;
    waited = 0;
    while (!(mem_req && mem_beat == 3'd4) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("abort reached_beat4", waited < 100, 1);
    reset = 1'b1;
    #1;
    chk("abort mem_req_drop", mem_req, 0);
    chk("abort no_ack", dc_ack, 0);
    chk("abort state", state_dbg, IDLE);
    dc_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort ack_stays_low", dc_ack, 0);
    end
    reset = 1'b0;
    ack_mode = 0;
    model_valid.delete();
    model_line.delete();
    last_load = 64'h0;
    model_op("abort reload", 58'h2A0, 3'd1, 3'd0, 64'h0, 1'b1, 2'd0);
    model_op("abort line40_invalid", 58'h40, 3'd3, 3'd0, 64'h0, 1'b1, 2'd0);

    for (int t = 0; t < 150; t++)
      model_op($sformatf("rand%0d", t), lines[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)));

`ifdef DCACHE_STATS_EN
    do_reset();
    chk("stats reset_hits", hit_count, 0);
    chk("stats reset_misses", miss_count, 0);
    model_op("stats miss", 58'h155, 3'd2, 3'd0, 64'h0, 1'b1, 2'd0);
    model_op("stats hit", 58'h155, 3'd2, 3'd0, 64'h0, 1'b1, 2'd0);
    model_op("stats store_hit", 58'h155, 3'd2, 3'd1, 64'h77, 1'b0, 2'd0);
    chk("stats hit_count", hit_count, 2);
    chk("stats miss_count", miss_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
